// File: rtl/lift_scheduler_pkg.sv
// ============================================================================
// Module  : lift_pkg
// Brief   : Shared types and constants for the lift scheduler.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package lift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DOOR   = 2'd3
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    CLR_NONE = 2'd0,
    CLR_UP   = 2'd1,
    CLR_DN   = 2'd2,
    CLR_BOTH = 2'd3
  } clr_sel_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lift_scheduler_if.sv
// ============================================================================
// Module  : lift_scheduler_if
// Brief   : Request-handler / actuator bundle; optional LIFT_SCHED_DOOR_HOLD_EN
//           adds i_door_hold.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface lift_scheduler_if #(
  parameter int N_FLOORS = 4
);
  logic [N_FLOORS-1:0] i_up_req_queue;
  logic [N_FLOORS-1:0] i_dn_req_queue;
  logic [N_FLOORS-1:0] i_flr_req_queue;
`ifdef LIFT_SCHED_DOOR_HOLD_EN
  logic                i_door_hold;
`endif
  logic [N_FLOORS-1:0] o_flr_pos;
  logic                o_up_clr;
  logic                o_dn_clr;
  logic                o_flr_clr;
  logic                o_dir_up;
  logic                o_moving;
  logic                o_door_open;
  logic                o_idle;

  modport master (
    input  i_up_req_queue, i_dn_req_queue, i_flr_req_queue,
`ifdef LIFT_SCHED_DOOR_HOLD_EN
    input  i_door_hold,
`endif
    output o_flr_pos, o_up_clr, o_dn_clr, o_flr_clr,
    output o_dir_up, o_moving, o_door_open, o_idle
  );

  modport slave (
    output i_up_req_queue, i_dn_req_queue, i_flr_req_queue,
`ifdef LIFT_SCHED_DOOR_HOLD_EN
    output i_door_hold,
`endif
    input  o_flr_pos, o_up_clr, o_dn_clr, o_flr_clr,
    input  o_dir_up, o_moving, o_door_open, o_idle
  );

endinterface

`default_nettype wire

// File: rtl/lift_scheduler_lookahead.sv
// ============================================================================
// Module  : lift_req_lookahead
// Brief   : Combinational request summary relative to the one-hot car floor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lift_req_lookahead #(
  parameter int N_FLOORS = 4
) (
  input  wire logic [N_FLOORS-1:0] up_q_i,
  input  wire logic [N_FLOORS-1:0] dn_q_i,
  input  wire logic [N_FLOORS-1:0] flr_q_i,
  input  wire logic [N_FLOORS-1:0] pos_i,
  output logic                     here_o,
  output logic                     above_o,
  output logic                     below_o,
  output logic                     here_up_o,
  output logic                     here_dn_o,
  output logic                     here_flr_o
);

  logic [N_FLOORS-1:0] w_any;
  logic [N_FLOORS-1:0] w_below_mask;
  logic [N_FLOORS-1:0] w_above_mask;

  // One-hot minus one yields every bit strictly below the car.
  assign w_below_mask = pos_i - N_FLOORS'(1);
  assign w_above_mask = ~(w_below_mask | pos_i);
  assign w_any        = up_q_i | dn_q_i | flr_q_i;

  assign here_up_o  = |(up_q_i  & pos_i);
  assign here_dn_o  = |(dn_q_i  & pos_i);
  assign here_flr_o = |(flr_q_i & pos_i);
  assign here_o     = here_up_o | here_dn_o | here_flr_o;
  assign above_o    = |(w_any & w_above_mask);
  assign below_o    = |(w_any & w_below_mask);

endmodule

`default_nettype wire

// File: rtl/lift_scheduler.sv
// ============================================================================
// Module  : lift_scheduler
// Brief   : SCAN car controller; define LIFT_SCHED_DOOR_HOLD_EN for door hold.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lift_scheduler
  import lift_pkg::*;
#(
  parameter int N_FLOORS      = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input wire logic          clk,
  input wire logic          reset,
  lift_scheduler_if.master  bus
);

  localparam int CNT_W = $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [N_FLOORS-1:0] FLOOR0   = N_FLOORS'(1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [N_FLOORS-1:0] pos_q;
  logic [N_FLOORS-1:0] pos_d;
  logic                dir_up_q;
  logic                moving_q;
  logic                door_q;
  logic                idle_q;
  logic                up_clr_q;
  logic                dn_clr_q;
  logic                flr_clr_q;

  logic     w_here, w_above, w_below, w_here_up, w_here_dn, w_here_flr;
  logic     w_ahead, w_behind, w_same_hall, w_opp_hall, w_dwell_done;
  clr_sel_e w_clr_sel;

  lift_req_lookahead #(
    .N_FLOORS (N_FLOORS)
  ) u_lookahead (
    .up_q_i     (bus.i_up_req_queue),
    .dn_q_i     (bus.i_dn_req_queue),
    .flr_q_i    (bus.i_flr_req_queue),
    .pos_i      (pos_q),
    .here_o     (w_here),
    .above_o    (w_above),
    .below_o    (w_below),
    .here_up_o  (w_here_up),
    .here_dn_o  (w_here_dn),
    .here_flr_o (w_here_flr)
  );

  assign w_ahead     = dir_up_q ? w_above   : w_below;
  assign w_behind    = dir_up_q ? w_below   : w_above;
  assign w_same_hall = dir_up_q ? w_here_up : w_here_dn;
  assign w_opp_hall  = dir_up_q ? w_here_dn : w_here_up;

`ifdef LIFT_SCHED_DOOR_HOLD_EN
  assign w_dwell_done = !bus.i_door_hold && (cnt_q == DOOR_LAST);
`else
  assign w_dwell_done = (cnt_q == DOOR_LAST);
`endif

  // Shift guarded at the shaft ends so the position can never leave range.
  always_comb begin
    pos_d = pos_q;
    if (dir_up_q == DIR_UP) begin
      if (!pos_q[N_FLOORS-1]) pos_d = pos_q << 1;
    end else begin
      if (!pos_q[0]) pos_d = pos_q >> 1;
    end
  end

  // Clear target chosen on the cycle the FSM decides to open the door.
  always_comb begin
    w_clr_sel = CLR_NONE;
    if (state_q == ST_IDLE) begin
      w_clr_sel = CLR_BOTH;
    end else if (w_here_flr || w_same_hall) begin
      w_clr_sel = dir_up_q ? CLR_UP : CLR_DN;
    end else begin
      w_clr_sel = dir_up_q ? CLR_DN : CLR_UP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pos_q     <= FLOOR0;
      dir_up_q  <= DIR_UP;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
      idle_q    <= 1'b1;
      up_clr_q  <= 1'b0;
      dn_clr_q  <= 1'b0;
      flr_clr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (w_here) begin
            state_q   <= ST_DOOR;
            door_q    <= 1'b1;
            idle_q    <= 1'b0;
            up_clr_q  <= (w_clr_sel == CLR_UP) || (w_clr_sel == CLR_BOTH);
            dn_clr_q  <= (w_clr_sel == CLR_DN) || (w_clr_sel == CLR_BOTH);
            flr_clr_q <= 1'b1;
          end else if (w_ahead || w_behind) begin
            if (!w_ahead) dir_up_q <= ~dir_up_q;
            state_q  <= ST_MOVING;
            moving_q <= 1'b1;
            idle_q   <= 1'b0;
          end
        end
        ST_MOVING: begin
          if (cnt_q == TRAVEL_LAST) begin
            pos_q    <= pos_d;
            cnt_q    <= '0;
            state_q  <= ST_CHECK;
            moving_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          cnt_q <= '0;
          if (w_here_flr || w_same_hall || (!w_ahead && w_opp_hall)) begin
            if (!(w_here_flr || w_same_hall)) dir_up_q <= ~dir_up_q;
            state_q   <= ST_DOOR;
            door_q    <= 1'b1;
            up_clr_q  <= (w_clr_sel == CLR_UP);
            dn_clr_q  <= (w_clr_sel == CLR_DN);
            flr_clr_q <= 1'b1;
          end else if (w_ahead) begin
            state_q  <= ST_MOVING;
            moving_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end
        end
        ST_DOOR: begin
          if (w_dwell_done) begin
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            door_q    <= 1'b0;
            idle_q    <= 1'b1;
            up_clr_q  <= 1'b0;
            dn_clr_q  <= 1'b0;
            flr_clr_q <= 1'b0;
`ifdef LIFT_SCHED_DOOR_HOLD_EN
          end else if (bus.i_door_hold) begin
            cnt_q <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_flr_pos   = pos_q;
  assign bus.o_up_clr    = up_clr_q;
  assign bus.o_dn_clr    = dn_clr_q;
  assign bus.o_flr_clr   = flr_clr_q;
  assign bus.o_dir_up    = dir_up_q;
  assign bus.o_moving    = moving_q;
  assign bus.o_door_open = door_q;
  assign bus.o_idle      = idle_q;

endmodule

`default_nettype wire
